sc_backg_row_reader: RTL and testbench

Read-side companion of the background-type row registers: scans the row register bank in order, fetches each row's data word and serializes it to the LED-matrix driver with shift-clock and latch strobes. Sits between the row register bank (through an address/data read port) and the matrix pins. Runs continuously while enabled and flags each completed frame.

---
 rtl/sc_backg_row_reader.sv | 167 ++++++++++++++++
 tb/tb_sc_backg_row_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_backg_row_reader.sv
// sc_backg_row_reader
// Scans the background-type row register bank in address order, fetches each
// row word through a registered read port and serializes it to the LED-matrix
// driver. Each row is shifted out bit by bit with a divided shift clock and
// then latched. frame_done_Out pulses once the last row has been latched.
//
// Build option:
//   SC_BACKGREADER_LSBFIRST_EN - when defined, bits go out LSB first;
//                                otherwise MSB first. Timing is identical.
//
// Ports:
//   SC_RegBACKGTYPE_14_CLOCK_50      system clock, rising edge
//   SC_RegBACKGTYPE_14_RESET_InHigh  async reset, active high
//   enable_In                        scanning runs while high
//   row_data_InBUS                   registered read data from the row bank
//   row_addr_OutBUS                  read address into the row bank
//   ser_data_Out                     serial data
//   ser_clk_Out                      serial clock (driver samples on rise)
//   ser_latch_Out                    latch strobe, active high
//   row_sel_OutBUS                   row currently displayed (updates at latch)
//   frame_done_Out                   one-cycle pulse in the NEXT state of the last row
//   busy_Out                         high whenever the FSM is not IDLE
//
// Every output is a flop. The flops are loaded from the next-state decode, so
// each output level lines up exactly with the state the FSM occupies.
module sc_backg_row_reader #(
  parameter int RegBACKGTYPE_DATAWIDTH = 8,
  parameter int NUM_ROWS               = 16,
  parameter int ROWADDR_WIDTH          = 4,
  parameter int CLKDIV                 = 4
) (
  input  logic                              SC_RegBACKGTYPE_14_CLOCK_50,
  input  logic                              SC_RegBACKGTYPE_14_RESET_InHigh,
  input  logic                              enable_In,
  input  logic [RegBACKGTYPE_DATAWIDTH-1:0] row_data_InBUS,
  output logic [ROWADDR_WIDTH-1:0]          row_addr_OutBUS,
  output logic                              ser_data_Out,
  output logic                              ser_clk_Out,
  output logic                              ser_latch_Out,
  output logic [ROWADDR_WIDTH-1:0]          row_sel_OutBUS,
  output logic                              frame_done_Out,
  output logic                              busy_Out
);

  localparam int DW   = RegBACKGTYPE_DATAWIDTH;
  localparam int DIVW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BITW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [ROWADDR_WIDTH-1:0] LAST_ROW = ROWADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [DIVW-1:0]          DIV_LAST = DIVW'(CLKDIV - 1);
  localparam logic [BITW-1:0]          BIT_LAST = BITW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SHIFT_LO, SHIFT_HI, LATCH, NEXT
  } state_t;

  state_t                   state, stateNext;
  logic [DW-1:0]            shiftReg, shiftRegNext;
  logic [DIVW-1:0]          divCnt, divCntNext;
  logic [BITW-1:0]          bitCnt, bitCntNext;
  logic [ROWADDR_WIDTH-1:0] rowAddrNext;
  logic                     serDataNext;
  logic                     curBitNext;
  logic [DW-1:0]            shiftedReg;

  // The bit on the wire is always taken from the end of the register that
  // leaves first; shifting moves the following bit into that position.
`ifdef SC_BACKGREADER_LSBFIRST_EN
  assign shiftedReg = {1'b0, shiftReg[DW-1:1]};
  assign curBitNext = shiftRegNext[0];
`else
  assign shiftedReg = {shiftReg[DW-2:0], 1'b0};
  assign curBitNext = shiftRegNext[DW-1];
`endif

  always_comb begin
    stateNext    = state;
    shiftRegNext = shiftReg;
    divCntNext   = divCnt;
    bitCntNext   = bitCnt;
    rowAddrNext  = row_addr_OutBUS;
    case (state)
      IDLE: begin
        if (enable_In) stateNext = FETCH;
      end
      // Address is already on the bus; the bank needs this cycle to register it.
      FETCH: stateNext = LOAD;
      LOAD: begin
        shiftRegNext = row_data_InBUS;
        bitCntNext   = '0;
        divCntNext   = '0;
        stateNext    = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (divCnt == DIV_LAST) begin
          divCntNext = '0;
          stateNext  = SHIFT_HI;
        end else begin
          divCntNext = divCnt + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (divCnt == DIV_LAST) begin
          divCntNext   = '0;
          shiftRegNext = shiftedReg;
          bitCntNext   = bitCnt + 1'b1;
          stateNext    = (bitCnt == BIT_LAST) ? LATCH : SHIFT_LO;
        end else begin
          divCntNext = divCnt + 1'b1;
        end
      end
      LATCH: begin
        if (divCnt == DIV_LAST) begin
          divCntNext = '0;
          stateNext  = NEXT;
        end else begin
          divCntNext = divCnt + 1'b1;
        end
      end
      NEXT: begin
        // Wrap at NUM_ROWS, which need not be a power of two.
        rowAddrNext = (row_addr_OutBUS == LAST_ROW) ? '0 : row_addr_OutBUS + 1'b1;
        stateNext   = enable_In ? FETCH : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Data changes only on entry to SHIFT_LO and is held through SHIFT_HI, which
  // gives CLKDIV cycles of setup and hold around every rising shift clock.
  always_comb begin
    serDataNext = 1'b0;
    if (stateNext == SHIFT_LO)      serDataNext = curBitNext;
    else if (stateNext == SHIFT_HI) serDataNext = ser_data_Out;
  end

  always_ff @(posedge SC_RegBACKGTYPE_14_CLOCK_50 or posedge SC_RegBACKGTYPE_14_RESET_InHigh) begin
    if (SC_RegBACKGTYPE_14_RESET_InHigh) begin
      state           <= IDLE;
      shiftReg        <= '0;
      divCnt          <= '0;
      bitCnt          <= '0;
      row_addr_OutBUS <= '0;
      row_sel_OutBUS  <= '0;
      ser_data_Out    <= 1'b0;
      ser_clk_Out     <= 1'b0;
      ser_latch_Out   <= 1'b0;
      frame_done_Out  <= 1'b0;
      busy_Out        <= 1'b0;
    end else begin
      state           <= stateNext;
      shiftReg        <= shiftRegNext;
      divCnt          <= divCntNext;
      bitCnt          <= bitCntNext;
      row_addr_OutBUS <= rowAddrNext;
      ser_data_Out    <= serDataNext;
      ser_clk_Out     <= (stateNext == SHIFT_HI);
      ser_latch_Out   <= (stateNext == LATCH);
      busy_Out        <= (stateNext != IDLE);
      // High for exactly the NEXT cycle that closes the last row.
      frame_done_Out  <= (stateNext == NEXT) && (row_addr_OutBUS == LAST_ROW);
      if (stateNext == LATCH && state != LATCH)
        row_sel_OutBUS <= row_addr_OutBUS;
    end
  end

endmodule

// File: tb/tb_sc_backg_row_reader.sv
// Directed bench for sc_backg_row_reader with default parameters. A model of
// the registered row bank feeds row_data_InBUS from a table of row words; each
// row's serial stream, latch width, row_sel and row period are checked against
// hand-computed table values. Hand-written sequences cover frame wrap, enable
// drop, data stability during shifting and reset in the middle of a row.
module tb_sc_backg_row_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] rowData;
  logic [3:0] rowAddr;
  logic       serData, serClk, serLatch, frameDone, busy;
  logic [3:0] rowSel;

  sc_backg_row_reader dut (
    .SC_RegBACKGTYPE_14_CLOCK_50     (clk),
    .SC_RegBACKGTYPE_14_RESET_InHigh (rst),
    .enable_In                       (enable),
    .row_data_InBUS                  (rowData),
    .row_addr_OutBUS                 (rowAddr),
    .ser_data_Out                    (serData),
    .ser_clk_Out                     (serClk),
    .ser_latch_Out                   (serLatch),
    .row_sel_OutBUS                  (rowSel),
    .frame_done_Out                  (frameDone),
    .busy_Out                        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] word;
    logic [7:0] expSer; // bits in wire order (first bit in bit 7), MSB-first build
  } vec_t;

  vec_t tbl [16];
  int   nTests = 0;
  int   nFail  = 0;
  int   cyc    = 0;
  int   lastRise = 0;
  bit   scr    = 1'b0;

  // frame_done monitor
  int         fdCount = 0;
  int         fdRun   = 0;
  int         fdMaxW  = 0;
  logic [3:0] fdAddr  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered row bank: data for the current address appears just after the edge.
  always @(posedge clk) begin
    #1;
    if (scr) rowData = 8'($urandom);
    else     rowData = tbl[rowAddr].word;
  end

  always @(negedge clk) begin
    if (frameDone) begin
      fdCount = fdCount + 1;
      fdRun   = fdRun + 1;
      fdAddr  = rowAddr;
      if (fdRun > fdMaxW) fdMaxW = fdRun;
    end else begin
      fdRun = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_rise(output bit ok);
    logic p;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      p = serClk;
      tick();
      if (!p && serClk) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  function automatic logic [7:0] wire_order(input logic [7:0] v);
`ifdef SC_BACKGREADER_LSBFIRST_EN
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
`else
    return v;
`endif
  endfunction

  // Checks one full row starting from before its first rising shift clock.
  task automatic check_row(input int idx, input bit chkLen, input bit scramble, input int dropBit);
    logic [7:0] got;
    bit ok;
    int lat;
    int rowStart;
    got = '0;
    rowStart = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == dropBit) begin
        for (int k = 0; k < 20 && serClk; k++) tick();
        enable = 1'b0;
      end
      wait_rise(ok);
      if (!ok) begin
        chk($sformatf("row%0d_rise%0d_timeout", idx, i), 0, 1);
        return;
      end
      if (i == 0) begin
        rowStart = cyc;
        if (chkLen) chk($sformatf("row%0d_period", idx), rowStart - lastRise, 71);
        chk($sformatf("row%0d_addr", idx), rowAddr, tbl[idx].addr);
        if (scramble) scr = 1'b1;
      end
      got = {got[6:0], serData};
    end
    scr = 1'b0;
    lastRise = rowStart;
    chk($sformatf("row%0d_bits", idx), got, wire_order(tbl[idx].expSer));
    for (int k = 0; k < 100 && !serLatch; k++) tick();
    chk($sformatf("row%0d_latch_seen", idx), serLatch, 1);
    chk($sformatf("row%0d_rowsel", idx), rowSel, tbl[idx].addr);
    lat = 0;
    while (serLatch && lat < 20) begin
      lat++;
      tick();
    end
    chk($sformatf("row%0d_latch_len", idx), lat, 4);
  endtask

  initial begin
    bit ok;
    int b;
    int highs;
    tbl = '{
      '{4'd0,  8'hA5, 8'hA5}, '{4'd1,  8'h3C, 8'h3C}, '{4'd2,  8'hFF, 8'hFF},
      '{4'd3,  8'h00, 8'h00}, '{4'd4,  8'h81, 8'h81}, '{4'd5,  8'h7E, 8'h7E},
      '{4'd6,  8'h55, 8'h55}, '{4'd7,  8'hAA, 8'hAA}, '{4'd8,  8'h01, 8'h01},
      '{4'd9,  8'h80, 8'h80}, '{4'd10, 8'h0F, 8'h0F}, '{4'd11, 8'hF0, 8'hF0},
      '{4'd12, 8'h12, 8'h12}, '{4'd13, 8'h34, 8'h34}, '{4'd14, 8'hC3, 8'hC3},
      '{4'd15, 8'h96, 8'h96}
    };
    rst = 1'b1;
    enable = 1'b0;
    rowData = '0;
    repeat (3) tick();
    chk("reset_ctrl", {busy, serClk, serLatch, serData, frameDone}, 5'b0);
    chk("reset_addr", rowAddr, 4'd0);
    chk("reset_sel", rowSel, 4'd0);
    rst = 1'b0;
    repeat (4) tick();
    chk("idle_no_busy", busy, 1'b0);

    // Full frame, rows 0..15 back to back
    enable = 1'b1;
    for (int r = 0; r < 16; r++) begin
      check_row(r, r > 0, 1'b0, -1);
      if (r == 14) chk("no_early_frame_done", fdCount, 0);
    end
    check_row(0, 1'b1, 1'b0, -1);
    chk("frame_done_count", fdCount, 1);
    chk("frame_done_width", fdMaxW, 1);
    chk("frame_done_addr", fdAddr, 4'd15);

    // Enable dropped during row 3 bit 2
    check_row(1, 1'b1, 1'b0, -1);
    check_row(2, 1'b1, 1'b0, -1);
    check_row(3, 1'b1, 1'b0, 2);
    for (int k = 0; k < 50 && busy; k++) tick();
    chk("drop_idle", busy, 1'b0);
    chk("drop_next_addr", rowAddr, 4'd4);
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (serClk || serLatch || busy) highs++;
    end
    chk("drop_stays_idle", highs, 0);

    // Resume at row 4; first rise 2+CLKDIV cycles after FETCH entry
    enable = 1'b1;
    for (int k = 0; k < 10 && !busy; k++) tick();
    b = cyc;
    check_row(4, 1'b0, 1'b0, -1);
    chk("first_rise_latency", lastRise - b, 6);

    // Row data scrambled while shifting
    check_row(5, 1'b1, 1'b1, -1);
    check_row(6, 1'b1, 1'b1, -1);

    // Reset in the middle of a SHIFT_HI phase
    wait_rise(ok);
    chk("row7_rise_before_reset", {ok, serClk}, 2'b11);
    chk("row7_addr", rowAddr, 4'd7);
    rst = 1'b1;
    #1;
    chk("midreset_ctrl", {busy, serClk, serLatch, serData, frameDone}, 5'b0);
    chk("midreset_addr_sel", {rowAddr, rowSel}, 8'h00);
    repeat (2) tick();
    rst = 1'b0;
    check_row(0, 1'b0, 1'b0, -1);
    chk("final_frame_done_count", fdCount, 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
